// File: rtl/divclk_freq_meter.sv
// Counts rising edges of an asynchronous divided clock over a fixed gate window
// of Clock cycles and reports the result as Count plus a one-cycle Valid strobe.
module divclk_freq_meter #(
    parameter int unsigned GATE_CYCLES = 1024,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Sel,
    input  logic             DivClk,
    output logic [CNT_W-1:0] Count,
    output logic             Valid,
    output logic             Overflow,
    output logic             Busy
);

    localparam int unsigned WIN_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GATE,
        ST_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;
    logic [WIN_W-1:0]       win_q, win_d;
    logic [CNT_W-1:0]       edges_q, edges_d;
    logic                   ovf_q, ovf_d;
    logic                   sel_q, sel_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;

    // DivClk synchroniser plus one history flop for rising-edge detection
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], DivClk};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            win_q      <= '0;
            edges_q    <= '0;
            ovf_q      <= 1'b0;
            sel_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            edges_q    <= edges_d;
            ovf_q      <= ovf_d;
            sel_q      <= sel_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    // Abort has priority over a Sel restart, which has priority over counting
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        edges_d    = edges_q;
        ovf_d      = ovf_q;
        sel_d      = sel_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Enable) begin
                    state_d = ST_GATE;
                    win_d   = WIN_LOAD;
                    edges_d = '0;
                    ovf_d   = 1'b0;
                    sel_d   = Sel;
                end
            end
            ST_GATE: begin
                if (!Enable) begin
                    state_d = ST_IDLE;
                end else if (Sel != sel_q) begin
                    win_d   = WIN_LOAD;
                    edges_d = '0;
                    ovf_d   = 1'b0;
                    sel_d   = Sel;
                end else begin
                    if (rise) begin
                        if (edges_q == CNT_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            edges_d = edges_q + CNT_W'(1);
                        end
                    end
                    if (win_q == '0) begin
                        state_d    = ST_DONE;
                        count_d    = edges_d;
                        overflow_d = ovf_d;
                        valid_d    = 1'b1;
                    end else begin
                        win_d = win_q - WIN_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (Enable) begin
                    state_d = ST_GATE;
                    win_d   = WIN_LOAD;
                    edges_d = '0;
                    ovf_d   = 1'b0;
                    sel_d   = Sel;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_GATE);
    end

    assign Count    = count_q;
    assign Overflow = overflow_q;
    assign Valid    = valid_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_divclk_freq_meter.sv
// Randomised bench for divclk_freq_meter: two instances (wide and narrow counter)
// checked each cycle against a window-sum reference model, plus literal checks.
`timescale 1ns/100ps
module tb_divclk_freq_meter;

    localparam int unsigned G0 = 1024;
    localparam int unsigned W0 = 16;
    localparam int unsigned G1 = 128;
    localparam int unsigned W1 = 4;
    localparam int unsigned S  = 2;
    localparam int HLEN = 40000;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic Enable = 1'b0;
    logic Sel = 1'b0;
    logic DivClk = 1'b0;

    logic [W0-1:0] count0;
    logic [W1-1:0] count1;
    logic valid0, valid1, ovf0, ovf1, busy0, busy1;

    divclk_freq_meter #(.GATE_CYCLES(G0), .CNT_W(W0), .SYNC_STAGES(S)) u_dut0 (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Sel(Sel), .DivClk(DivClk),
        .Count(count0), .Valid(valid0), .Overflow(ovf0), .Busy(busy0)
    );

    divclk_freq_meter #(.GATE_CYCLES(G1), .CNT_W(W1), .SYNC_STAGES(S)) u_dut1 (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Sel(Sel), .DivClk(DivClk),
        .Count(count1), .Valid(valid1), .Overflow(ovf1), .Busy(busy1)
    );

    always #5 Clock = ~Clock;

    // DivClk source: 0 = stopped low, >0 = fixed half period, <0 = random half periods
    int half_mode = 0;
    int ph = 0;
    int cur_half = 2;
    always @(negedge Clock) begin
        if (half_mode == 0) begin
            DivClk = 1'b0;
            ph = 0;
        end else begin
            if (half_mode > 0) cur_half = half_mode;
            ph++;
            if (ph >= cur_half) begin
                DivClk = ~DivClk;
                ph = 0;
                if (half_mode < 0) cur_half = $urandom_range(2, 9);
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic d_hist [0:HLEN-1];

    // reference model state: 0 idle, 1 gating, 2 result cycle
    int m_st [2];
    int m_start [2];
    int m_cnt [2];
    int m_ovf [2];
    logic m_selq [2];
    int gate_len [2];
    int cnt_max [2];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    // DivClk edge counted at Clock edge k, given the synchroniser latency
    function automatic int rise_at(input int k);
        if (k - int'(S) - 1 < 1) return 0;
        return (d_hist[k-S] === 1'b1 && d_hist[k-S-1] === 1'b0) ? 1 : 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0;
            m_start[i] = 0;
            m_cnt[i] = 0;
            m_ovf[i] = 0;
            m_selq[i] = 1'b0;
        end
    endtask

    task automatic m_step(input int i, input int n);
        int total;
        case (m_st[i])
            0: if (Enable) begin
                m_st[i] = 1; m_start[i] = n + 1; m_selq[i] = Sel;
            end
            1: if (!Enable) begin
                m_st[i] = 0;
            end else if (Sel != m_selq[i]) begin
                m_start[i] = n + 1; m_selq[i] = Sel;
            end else if (n == m_start[i] + gate_len[i] - 1) begin
                total = 0;
                for (int k = m_start[i]; k <= n; k++) total += rise_at(k);
                m_cnt[i] = (total > cnt_max[i]) ? cnt_max[i] : total;
                m_ovf[i] = (total > cnt_max[i]) ? 1 : 0;
                m_st[i] = 2;
            end
            default: if (Enable) begin
                m_st[i] = 1; m_start[i] = n + 1; m_selq[i] = Sel;
            end else begin
                m_st[i] = 0;
            end
        endcase
    endtask

    // one Clock edge: advance the model, then compare every output of both instances
    task automatic tick();
        @(posedge Clock);
        cyc++;
        if (cyc >= HLEN) begin
            $display("FAIL run_length: got %0d cycles expected below %0d", cyc, HLEN);
            $fatal(1, "cycle budget exhausted");
        end
        d_hist[cyc] = Reset ? 1'b0 : DivClk;
        if (Reset) m_reset();
        else for (int i = 0; i < 2; i++) m_step(i, cyc);
        #1;
        if (!Reset) begin
            chk("valid0", int'(valid0), (m_st[0] == 2) ? 1 : 0);
            chk("busy0", int'(busy0), (m_st[0] == 1) ? 1 : 0);
            chk("count0", int'(count0), m_cnt[0]);
            chk("ovf0", int'(ovf0), m_ovf[0]);
            chk("valid1", int'(valid1), (m_st[1] == 2) ? 1 : 0);
            chk("busy1", int'(busy1), (m_st[1] == 1) ? 1 : 0);
            chk("count1", int'(count1), m_cnt[1]);
            chk("ovf1", int'(ovf1), m_ovf[1]);
        end
    endtask

    task automatic wait_valid(input int which, input int budget, output int vcyc);
        bit found = 0;
        vcyc = -1;
        for (int b = 0; b < budget && !found; b++) begin
            tick();
            if ((which == 0 && valid0) || (which == 1 && valid1)) begin
                found = 1;
                vcyc = cyc + 1;
            end
        end
        chk("valid_within_budget", int'(found), 1);
    endtask

    initial begin
        int e, v, v1, v2, s, saved, seen, off, rc;
        gate_len[0] = G0; gate_len[1] = G1;
        cnt_max[0] = (1 << W0) - 1; cnt_max[1] = (1 << W1) - 1;
        m_reset();

        repeat (3) tick();
        Reset = 1'b0;
        repeat (2) tick();
        chk("reset_count0", int'(count0), 0);
        chk("reset_valid0", int'(valid0), 0);
        chk("reset_busy0", int'(busy0), 0);
        chk("reset_ovf0", int'(ovf0), 0);

        // Clock/4 window: 256 edges, result in the 1025th cycle after Enable
        half_mode = 2;
        repeat (20) tick();
        Enable = 1'b1;
        tick();
        e = cyc;
        chk("t1_busy", int'(busy0), 1);
        wait_valid(0, 1100, v);
        chk("t1_latency", v - e, 1025);
        chk_rng("t1_count", int'(count0), 255, 257);
        chk("t1_ovf", int'(ovf0), 0);
        chk("t1_sat_count1", int'(count1), 15);
        chk("t1_sat_ovf1", int'(ovf1), 1);

        // Clock/8 back-to-back windows
        half_mode = 4;
        wait_valid(0, 1100, v1);
        wait_valid(0, 1100, v2);
        chk("t2_period", v2 - v1, 1025);
        chk_rng("t2_count", int'(count0), 127, 129);

        // Sel change mid-window restarts it at the new rate
        repeat (480) tick();
        half_mode = 2;
        repeat (20) tick();
        Sel = ~Sel;
        tick();
        s = cyc;
        wait_valid(0, 1100, v);
        chk("t3_restart_latency", v - s, 1025);
        chk_rng("t3_count", int'(count0), 255, 257);

        // stopped DivClk gives a clean zero on the narrow instance
        half_mode = 0;
        wait_valid(1, 300, v);
        wait_valid(1, 300, v);
        chk("t4_count1", int'(count1), 0);
        chk("t4_ovf1", int'(ovf1), 0);

        // abort at cycle 300 of a window
        half_mode = 2;
        wait_valid(0, 1100, v);
        saved = int'(count0);
        repeat (300) tick();
        Enable = 1'b0;
        tick();
        chk("t5_busy_drop", int'(busy0), 0);
        seen = 0;
        repeat (1100) begin
            tick();
            if (valid0) seen++;
        end
        chk("t5_no_valid", seen, 0);
        chk("t5_count_hold", int'(count0), saved);

        // short asynchronous reset mid-window
        Enable = 1'b1;
        repeat (200) tick();
        #1 Reset = 1'b1;
        #0.5;
        chk("t6_count0", int'(count0), 0);
        chk("t6_valid0", int'(valid0), 0);
        chk("t6_busy0", int'(busy0), 0);
        chk("t6_count1", int'(count1), 0);
        #0.5 Reset = 1'b0;
        rc = cyc;
        m_reset();
        for (int k = rc - int'(S); k <= rc; k++) if (k >= 0) d_hist[k] = 1'b0;
        wait_valid(0, 1100, v);
        chk("t6_restart_latency", v - (rc + 1), 1025);
        chk_rng("t6_count", int'(count0), 255, 257);

        // random DivClk rate with occasional Sel toggles and Enable drops
        half_mode = -1;
        off = 0;
        repeat (8000) begin
            if (off > 0) begin
                off--;
                if (off == 0) Enable = 1'b1;
            end else if ($urandom_range(0, 1499) == 0) begin
                off = $urandom_range(1, 20);
                Enable = 1'b0;
            end
            if ($urandom_range(0, 1999) == 0) Sel = ~Sel;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
